load_store_unit: RTL

//  Sits between execute stage and data_memory (32 x 32-bit words, 5-bit word addr, registered read_out).

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 32 x 32-bit registered-read data memory.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read_flag,
  output logic              mem_write_flag,
  output logic [4:0]        mem_addr,
  output logic [31:0]       mem_val,
  input  logic [31:0]       mem_read_out
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd   = 3'd1;
  localparam logic [2:0] StLdx  = 3'd2;
  localparam logic [2:0] StWr   = 3'd3;
  localparam logic [2:0] StResp = 3'd4;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeIll  = 2'b11;

  logic [2:0]        state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              req_bad;
  logic [1:0]        req_size_n;
  logic              req_is_word;

  logic [4:0]        lane_shift;
  logic [31:0]       shifted_rd;
  logic [15:0]       half_lane;
  logic [31:0]       ld_ext;
  logic [31:0]       merged;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  assign req_bad = (req_size == SizeIll) ||
                   ((req_size == SizeHalf) && req_addr[0]) ||
                   ((req_size == SizeWord) && (req_addr[1:0] != 2'b00));
  assign req_size_n = req_size;
  assign resp_err   = err_q;
`else
  // Without the trap, size 11 behaves as a word and low address bits are dropped.
  assign req_bad    = 1'b0;
  assign req_size_n = (req_size == SizeIll) ? SizeWord : req_size;
  assign resp_err   = 1'b0;
`endif

  assign accept      = (state_q == StIdle) && req_valid;
  assign req_is_word = (req_size_n == SizeWord);

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = (state_q == StResp);
  assign resp_rdata     = rdata_q;
  assign mem_read_flag  = (state_q == StRd);
  assign mem_write_flag = (state_q == StWr);
  assign mem_addr       = 5'(addr_q[ADDR_W-1:2]);

  // Lane extraction and merge both work on the registered memory read data.
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign shifted_rd = mem_read_out >> lane_shift;
  assign half_lane  = addr_q[1] ? mem_read_out[31:16] : mem_read_out[15:0];

  always_comb begin
    ld_ext = mem_read_out;
    unique case (size_q)
      SizeByte: ld_ext = unsigned_q ? {24'h0, shifted_rd[7:0]}
                                    : {{24{shifted_rd[7]}}, shifted_rd[7:0]};
      SizeHalf: ld_ext = unsigned_q ? {16'h0, half_lane}
                                    : {{16{half_lane[15]}}, half_lane};
      default:  ld_ext = mem_read_out;
    endcase
  end

  always_comb begin
    merged = wdata_q;
    unique case (size_q)
      SizeByte: merged = (mem_read_out & ~(32'h0000_00ff << lane_shift)) |
                         ({24'h0, wdata_q[7:0]} << lane_shift);
      SizeHalf: merged = addr_q[1] ? {wdata_q[15:0], mem_read_out[15:0]}
                                   : {mem_read_out[31:16], wdata_q[15:0]};
      default:  merged = wdata_q;
    endcase
  end

  assign mem_val = (state_q == StWr) ? merged : 32'h0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_bad) begin
            state_d = StResp;
          end else if (req_we && req_is_word) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = we_q ? StWr : StLdx;
      StLdx:   state_d = StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      we_q       <= req_we;
      size_q     <= req_size_n;
      unsigned_q <= req_unsigned;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
    end
  end

  // Response data is held until the next response is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (state_q == StLdx) begin
      rdata_q <= ld_ext;
    end else if ((state_q == StWr) || (accept && req_bad)) begin
      rdata_q <= 32'h0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && req_bad) begin
      err_q <= 1'b1;
    end else if ((state_q == StLdx) || (state_q == StWr)) begin
      err_q <= 1'b0;
    end
  end
`endif

endmodule
